// File: rtl/cdc_fifo_aggregator.sv
// Dual-clock word packer: gray-pointer async FIFO (wclk -> clk) feeding a lane packer.
// Define LANE_MSB_FIRST_EN to place the first word of a group in the most significant lane.
module cdc_fifo_aggregator #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH  = 2
) (
  input  logic                              wclk,
  input  logic                              wrst_n,
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              w_enq,
  input  logic [DATA_WIDTH-1:0]             w_data,
  output logic                              w_full_n,
  input  logic                              r_full_n,
  output logic                              r_enq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] r_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned CW    = $clog2(FETCH_WIDTH + 1);
  // Full when the write gray pointer equals the read gray pointer with its top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write domain
  logic [PW-1:0] wbin, wgray, wbin_nxt, wgray_nxt, rgray_w1, rgray_w2;
  logic          wr;

  always_comb begin
    wr        = w_enq && w_full_n;
    wbin_nxt  = wbin + PW'(wr);
    wgray_nxt = bin2gray(wbin_nxt);
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin     <= '0;
      wgray    <= '0;
      rgray_w1 <= '0;
      rgray_w2 <= '0;
      w_full_n <= 1'b0;
    end else begin
      wbin     <= wbin_nxt;
      wgray    <= wgray_nxt;
      rgray_w1 <= rgray;
      rgray_w2 <= rgray_w1;
      w_full_n <= (wgray_nxt != (rgray_w2 ^ FULL_MASK));
    end
  end

  always_ff @(posedge wclk) begin
    if (wr) mem[wbin[ADDR_WIDTH-1:0]] <= w_data;
  end

  // Read / aggregation domain
  logic [PW-1:0]         rbin, rbin_nxt, rgray, wgray_r1, wgray_r2;
  logic                  empty_n, deq;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         cnt, lane_slot, lane_sel;
  logic [DATA_WIDTH-1:0] lanes [FETCH_WIDTH];

  always_comb begin
    empty_n   = (rgray != wgray_r2);
    head      = mem[rbin[ADDR_WIDTH-1:0]];
    r_enq     = (cnt == CW'(FETCH_WIDTH)) && r_full_n;
    deq       = empty_n && ((cnt < CW'(FETCH_WIDTH)) || r_enq);
    rbin_nxt  = rbin + PW'(deq);
    // An emitting cycle restarts the group, so a refill word lands in the first lane.
    lane_slot = r_enq ? '0 : cnt;
`ifdef LANE_MSB_FIRST_EN
    lane_sel  = CW'(FETCH_WIDTH - 1) - lane_slot;
`else
    lane_sel  = lane_slot;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbin     <= '0;
      rgray    <= '0;
      wgray_r1 <= '0;
      wgray_r2 <= '0;
      cnt      <= '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) lanes[i] <= '0;
    end else begin
      wgray_r1 <= wgray;
      wgray_r2 <= wgray_r1;
      rbin     <= rbin_nxt;
      rgray    <= bin2gray(rbin_nxt);
      if (r_enq)    cnt <= deq ? CW'(1) : '0;
      else if (deq) cnt <= cnt + CW'(1);
      for (int unsigned i = 0; i < FETCH_WIDTH; i++)
        if (deq && (CW'(i) == lane_sel)) lanes[i] <= head;
    end
  end

  always_comb begin
    r_data = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++)
      r_data[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
  end

endmodule

// File: tb/tb_cdc_fifo_aggregator.sv
// Bench for cdc_fifo_aggregator: queue-based model of accepted words, grouped per emitted word,
// plus directed reset / backpressure / odd-count / random-stall / wrap scenarios.
`timescale 1ns/10ps
module tb_cdc_fifo_aggregator;
  localparam int unsigned DW = 8;
  localparam int unsigned FW = 2;
  localparam int unsigned AW = 2;

  logic wclk = 1'b0;
  logic clk  = 1'b0;
  logic wrst_n, rst_n, w_enq, w_full_n, r_full_n, r_enq;
  logic [DW-1:0]    w_data;
  logic [FW*DW-1:0] r_data;

  cdc_fifo_aggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .ADDR_WIDTH(AW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .clk(clk), .rst_n(rst_n),
    .w_enq(w_enq), .w_data(w_data), .w_full_n(w_full_n),
    .r_full_n(r_full_n), .r_enq(r_enq), .r_data(r_data)
  );

  always #20 wclk = ~wclk;
  always #6.65 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned emits = 0;
  int unsigned bp_mode = 0;
  bit          in_reset = 1'b1;
  logic [DW-1:0]    q [$];
  logic [FW*DW-1:0] log_mem [200];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Receiver readiness: driven just after each clk edge.
  initial begin
    r_full_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       r_full_n = 1'b1;
        1:       r_full_n = 1'b0;
        default: r_full_n = 1'($urandom_range(1));
      endcase
    end
  end

  // Every emitted word must be the next FW accepted words, oldest in lane 0.
  always @(negedge clk) begin
    if (!in_reset && rst_n && wrst_n && r_enq) begin
      logic [FW*DW-1:0] e;
      bit ok;
      ok = r_full_n && (q.size() >= FW);
      e  = '0;
      if (q.size() >= FW) begin
        for (int i = 0; i < FW; i++) begin
`ifdef LANE_MSB_FIRST_EN
          e[(FW-1-i)*DW +: DW] = q.pop_front();
`else
          e[i*DW +: DW] = q.pop_front();
`endif
        end
      end
      total++;
      if (!ok || r_data !== e) begin
        bad++;
        $display("FAIL stream_word %0d: got %h want %h (ready=%0b queued=%0d)",
                 emits, r_data, e, r_full_n, q.size());
      end
      if (emits < 200) log_mem[emits] = r_data;
      emits++;
    end
  end

  task automatic write_seq(input int unsigned first, input int unsigned n, input int unsigned stall_pct,
                           input int unsigned max_cyc, output int unsigned acc);
    int unsigned cyc;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < max_cyc) begin
      @(negedge wclk);
      w_enq  = ($urandom_range(99) >= stall_pct);
      w_data = DW'(first + acc);
      if (w_enq && w_full_n) begin
        q.push_back(w_data);
        acc++;
      end
      cyc++;
    end
    @(negedge wclk);
    w_enq = 1'b0;
  endtask

  task automatic wait_emits(input int unsigned target, input int unsigned budget, input string name);
    int unsigned c;
    c = 0;
    while (emits < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (20) @(negedge clk);
    check(name, 32'(emits), 32'(target));
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    w_enq  = 1'b0;
    wrst_n = 1'b0;
    rst_n  = 1'b0;
    repeat (5) @(posedge wclk);
    q.delete();
    emits = 0;
    @(negedge wclk);
    wrst_n   = 1'b1;
    rst_n    = 1'b1;
    in_reset = 1'b0;
    @(negedge wclk);
  endtask

  int unsigned acc;

  initial begin
    wrst_n = 1'b0;
    rst_n  = 1'b0;
    w_enq  = 1'b0;
    w_data = '0;
    repeat (5) @(posedge wclk);
    @(negedge wclk);
    check("rst_w_full_n", 32'(w_full_n), 32'd0);
    check("rst_r_enq",    32'(r_enq),    32'd0);
    check("rst_r_data",   32'(r_data),   32'd0);
    wrst_n = 1'b1;
    rst_n  = 1'b1;
    in_reset = 1'b0;
    @(negedge wclk);
    check("post_rst_w_full_n", 32'(w_full_n), 32'd1);
    repeat (20) @(negedge clk);
    check("idle_no_enq", 32'(emits), 32'd0);

    // Backpressure with w_enq held through the full period (overflow attempts dropped).
    bp_mode = 1;
    write_seq(0, 10, 0, 40, acc);
    check("bp_accepted",  32'(acc),      32'd6);
    check("bp_w_full_n",  32'(w_full_n), 32'd0);
    check("bp_hold_data", 32'(r_data),   32'h0100);
    check("bp_no_enq",    32'(emits),    32'd0);
    bp_mode = 0;
    write_seq(6, 4, 0, 100, acc);
    check("bp_rest_accepted", 32'(acc), 32'd4);
    wait_emits(5, 300, "bp_emits");
    check("bp_word0", 32'(log_mem[0]), 32'h0100);
    check("bp_word1", 32'(log_mem[1]), 32'h0302);
    check("bp_word2", 32'(log_mem[2]), 32'h0504);

    // Odd count: the third word waits for a partner.
    do_reset();
    write_seq(0, 3, 0, 50, acc);
    wait_emits(1, 200, "odd_emits1");
    check("odd_word0", 32'(log_mem[0]), 32'h0100);
    write_seq(3, 1, 0, 50, acc);
    wait_emits(2, 200, "odd_emits2");
    check("odd_word1", 32'(log_mem[1]), 32'h0302);

    // Stream with random write stalls.
    do_reset();
    write_seq(0, 40, 40, 400, acc);
    check("stream_accepted", 32'(acc), 32'd40);
    wait_emits(20, 400, "stream_emits");
    check("stream_word5", 32'(log_mem[5]), 32'h0b0a);

    // Pointer and data wrap, with random receiver backpressure.
    do_reset();
    bp_mode = 2;
    write_seq(1, 300, 10, 2000, acc);
    check("wrap_accepted", 32'(acc), 32'd300);
    bp_mode = 0;
    wait_emits(150, 2000, "wrap_emits");
    check("wrap_word127", 32'(log_mem[127]), 32'h00ff);
    check("wrap_word149", 32'(log_mem[149]), 32'h2c2b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
